// File: rtl/nios2_proc_adc_spi_ctrl_pkg.sv
// Shared definitions for the Avalon-MM ADC SPI controller: register map,
// bit positions, FSM states and frame geometry.
package nios2_proc_adc_spi_ctrl_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CONT    = 1;
  localparam int CTRL_CH_LO   = 2;
  localparam int CTRL_CH_HI   = 4;
  localparam int STATUS_BUSY  = 0;
  localparam int STATUS_VALID = 1;

  localparam int SPI_FRAME_BITS = 16;
  localparam int RESULT_BITS    = 12;

  // Periods are counted 0-based inside the RTL.
  localparam logic [3:0] CH_FIRST_PERIOD     = 4'd2;
  localparam logic [3:0] RESULT_FIRST_PERIOD = 4'(SPI_FRAME_BITS - RESULT_BITS);
  localparam logic [3:0] LAST_PERIOD         = 4'(SPI_FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } state_e;

  function automatic logic din_bit(input logic [3:0] period, input logic [2:0] ch);
    logic b;
    b = 1'b0;
    if (period == CH_FIRST_PERIOD)               b = ch[2];
    else if (period == CH_FIRST_PERIOD + 4'd1)   b = ch[1];
    else if (period == CH_FIRST_PERIOD + 4'd2)   b = ch[0];
    return b;
  endfunction

endpackage

// File: rtl/nios2_proc_adc_spi_ctrl_clkgen.sv
// Half-period counter for the ADC serial clock; produces per-phase strobes
// while shifting and first/last-cycle markers for the timed FSM states.
module adc_spi_clkgen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  output logic half_first,
  output logic half_last,
  output logic fall_stb,
  output logic sample_stb,
  output logic rise_stb
);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;

  assign half_first = (cnt_q == 8'd0);
  assign half_last  = (cnt_q == 8'(CLK_DIV - 1));

  always_comb begin
    cnt_d   = cnt_q + 8'd1;
    phase_d = phase_q;
    if (clr) begin
      cnt_d   = 8'd0;
      phase_d = 1'b0;
    end else if (half_last) begin
      cnt_d = 8'd0;
      if (shift_en) phase_d = ~phase_q;
    end
  end

  // phase_q=0 is the SCLK low phase; the edge after its last cycle raises SCLK.
  assign fall_stb   = shift_en &  phase_q & half_last;
  assign sample_stb = shift_en & ~phase_q & half_last;
  assign rise_stb   = sample_stb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/nios2_proc_adc_spi_ctrl.sv
// Avalon-MM slave driving a 16-bit SPI ADC frame; single-shot or continuous
// conversions with the 12-bit result exposed as a register and an 8-bit PIO feed.
module nios2_proc_adc_spi_ctrl
  import nios2_proc_adc_spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [7:0]  data_out,
  output logic        done
);

  state_e                 state_q, state_d;
  logic                   start_q, start_d;
  logic                   cont_q, cont_d;
  logic [2:0]             ch_q, ch_d;
  logic [2:0]             ch_lat_q, ch_lat_d;
  logic [3:0]             per_q, per_d;
  logic [RESULT_BITS-1:0] res_q, res_d;
  logic [RESULT_BITS-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   done_q, done_d;
  logic                   cs_n_q, cs_n_d;
  logic                   sclk_q, sclk_d;
  logic                   din_q, din_d;
  logic [31:0]            readdata_q, readdata_d;

  logic enter_setup, busy;
  logic half_first, half_last, fall_stb, sample_stb, rise_stb;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:CTRL_CH_HI+1];
  assign busy         = (state_q != ST_IDLE);

  adc_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk        (clk),
    .rst        (reset),
    .clr        (state_d != state_q),
    .shift_en   (state_q == ST_SHIFT),
    .half_first (half_first),
    .half_last  (half_last),
    .fall_stb   (fall_stb),
    .sample_stb (sample_stb),
    .rise_stb   (rise_stb)
  );

  always_comb begin
    state_d     = state_q;
    ch_lat_d    = ch_lat_q;
    per_d       = per_q;
    res_d       = res_q;
    data_d      = data_q;
    done_d      = 1'b0;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    din_d       = din_q;
    enter_setup = 1'b0;

    case (state_q)
      ST_IDLE:  enter_setup = start_q | cont_q;
      ST_SETUP: if (half_last) begin
        state_d = ST_SHIFT;
        sclk_d  = 1'b0;
      end
      ST_SHIFT: begin
        if (sample_stb && per_q >= RESULT_FIRST_PERIOD)
          res_d = {res_q[RESULT_BITS-2:0], adc_dout};
        if (rise_stb) sclk_d = 1'b1;
        if (fall_stb) begin
          if (per_q == LAST_PERIOD) begin
            state_d = ST_HOLD;
            cs_n_d  = 1'b1;
            din_d   = 1'b0;
          end else begin
            per_d  = per_q + 4'd1;
            sclk_d = 1'b0;
            din_d  = din_bit(per_q + 4'd1, ch_lat_q);
          end
        end
      end
      ST_HOLD: begin
        if (half_first) begin
          data_d = res_q;
          done_d = 1'b1;
        end
        // Continuous mode re-enters SETUP directly so cs_n idles for exactly one HOLD.
        if (half_last) begin
          if (cont_q) enter_setup = 1'b1;
          else        state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_setup) begin
      state_d  = ST_SETUP;
      cs_n_d   = 1'b0;
      ch_lat_d = ch_q;
      per_d    = 4'd0;
    end
  end

  always_comb begin
    cont_d  = cont_q;
    ch_d    = ch_q;
    start_d = 1'b0;
    if (write && address == REG_CTRL) begin
      cont_d  = writedata[CTRL_CONT];
      ch_d    = writedata[CTRL_CH_HI:CTRL_CH_LO];
      start_d = writedata[CTRL_START] && (state_d == ST_IDLE);
    end

    valid_d = valid_q;
    if (read && address == REG_STATUS) valid_d = 1'b0;
    if (done_d)                        valid_d = 1'b1;

    readdata_d = readdata_q;
    if (read) begin
      case (address)
        REG_CTRL:   readdata_d = {27'd0, ch_q, cont_q, 1'b0};
        REG_STATUS: readdata_d = {30'd0, valid_q, busy};
        REG_DATA:   readdata_d = {20'd0, data_q};
        REG_RSVD:   readdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      cont_q     <= 1'b0;
      ch_q       <= 3'd0;
      ch_lat_q   <= 3'd0;
      per_q      <= 4'd0;
      res_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      din_q      <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      cont_q     <= cont_d;
      ch_q       <= ch_d;
      ch_lat_q   <= ch_lat_d;
      per_q      <= per_d;
      res_q      <= res_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      din_q      <= din_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign adc_din  = din_q;
  assign data_out = data_q[RESULT_BITS-1:RESULT_BITS-8];
  assign done     = done_q;

endmodule
